keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Drives the column lines of a 4x4 matrix keypad one at a time and samples the row lines to find a pressed key. It debounces both press and release with an internal counter. Each accepted press produces exactly one key_valid pulse and a registered 4-bit key code. The block sits between the keypad pins (behind external 2-flop row synchronizers) and the display/key-history logic.

Parameters:
SCAN_DIV, 16'd4800, clk cycles each column is driven before rows are sampled (settle/dwell time; 100 us at 48 MHz).
DEBOUNCE_CYCLES, 22'd2400000, consecutive stable cycles required to accept a press or a release (50 ms at 48 MHz).

Ports:
clk  in  1  system clock
reset  in  1  reset, synchronous, active-high
rows_n  in  4  keypad rows, active-low (pulled up), already synchronized
cols_n  out  4  column drive, active-low one-hot; all other columns high
key_code  out  4  code of the most recently accepted key
key_valid  out  1  one-cycle pulse when a press is accepted
key_held  out  1  high while the accepted key remains pressed (through release debounce)

Behaviour:
- Reset values: state=SCAN, col_idx=0, cols_n=4'b1110, key_code=0, key_valid=0, key_held=0, dwell and debounce counters=0. Reset applied mid-operation aborts any state immediately, with no key_valid pulse.
- cols_n is always ~(1<<col_idx) and is registered. col_idx changes only in SCAN at the dwell end, or on exit from DEBOUNCE_RELEASE or an aborted press.
- SCAN:
  - The dwell counter counts 0..SCAN_DIV-1. At count SCAN_DIV-1 (the sample cycle), rows_n is sampled.
  - If any row is low: latch col_idx and row index (lowest-index low row wins), clear the debounce counter, go to DEBOUNCE_PRESS.
  - Otherwise col_idx advances (3 wraps to 0) and the dwell counter restarts.
- DEBOUNCE_PRESS:
  - Columns are frozen.
  - Each cycle the latched row is low, the counter increments.
  - If the latched row reads high on any cycle: clear the counter, advance col_idx, return to SCAN (glitch rejected, no pulse).
  - When the counter reaches DEBOUNCE_CYCLES-1 with the row still low: go to HELD, register key_code, and assert key_valid for exactly the next cycle.
  - key_valid rises exactly DEBOUNCE_CYCLES+1 cycles after the sample cycle.
- HELD:
  - key_held=1; columns are frozen.
  - Other keys pressed simultaneously are ignored.
  - When the latched row reads high: clear the counter and go to DEBOUNCE_RELEASE.
- DEBOUNCE_RELEASE:
  - key_held stays 1.
  - Each cycle the latched row is high, the counter increments.
  - If the row goes low again: return to HELD with no new key_valid.
  - When the counter reaches DEBOUNCE_CYCLES-1: key_held=0, advance col_idx, go to SCAN.
- key_code holds its value until the next accepted press.
- Key map (row r, col c), row 0 first: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D. Digit keys map to their value; A-F map to 0xA-0xF.
- Counter widths: dwell counter is 16 bits; debounce counter is 22 bits. Neither wraps; both are compared with ==.

Decomposition:
- Package keypad_pkg holds:
  - state enum typedef (SCAN, DEBOUNCE_PRESS, HELD, DEBOUNCE_RELEASE)
  - NUM_ROWS=4 and NUM_COLS=4 constants
  - 4x4 key-map constant array
- Sub-module keypad_key_decode: combinational row/col index to 4-bit code lookup. It is instantiated once and feeds the key_code register.

Test Plan:
Use SCAN_DIV=4 and DEBOUNCE_CYCLES=8 throughout.
1. Reset -> cols_n=1110, key_code=0, key_valid=0, key_held=0; with rows_n=1111, cols_n cycles 1110,1101,1011,0111,1110 every 4 clk.
2. Hold row 1 low only while cols_n=1101 (key "5") -> sampled; key_valid high for exactly 1 cycle, 9 cycles after the sample; key_code=4'h5; key_held=1; cols_n frozen at 1101.
3. Low pulse of 3 cycles on row 0 during DEBOUNCE_PRESS for col 3 -> no key_valid, key_code unchanged, scanning resumes at col 0.
4. Release key "5" with a 2-cycle bounce back low, then stay high -> no second key_valid; key_held falls 8 stable-high cycles after the final rise; scanning resumes at col 2.
5. Press "E" (row 3, col 0) and "1" (row 0, col 0) together -> key_code=4'h1; while held, press "9" -> ignored, no pulse.
6. Assert reset during HELD and during DEBOUNCE_PRESS -> next cycle all outputs are at reset values and no key_valid pulse appears.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   state_t     - scanner FSM states
//   NUM_ROWS/COLS - matrix dimensions
//   KEY_MAP     - key code per [row][col], row 0 is the top row
//   col_drive   - active-low one-hot column drive for a column index
//   lowest_low_row - index of the lowest-numbered row reading low
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    SCAN             = 2'd0,
    DEBOUNCE_PRESS   = 2'd1,
    HELD             = 2'd2,
    DEBOUNCE_RELEASE = 2'd3
  } state_t;

  // Keypad legend, row 0 first: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
  localparam logic [3:0] KEY_MAP [NUM_ROWS][NUM_COLS] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] col);
    return ~(4'b0001 << col);
  endfunction

  // Only meaningful when at least one row is low; row 3 is the fallback.
  function automatic logic [1:0] lowest_low_row(input logic [NUM_ROWS-1:0] rows_n);
    if (!rows_n[0])      return 2'd0;
    else if (!rows_n[1]) return 2'd1;
    else if (!rows_n[2]) return 2'd2;
    else                 return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_key_decode.sv
// keypad_key_decode: combinational lookup of a key code from the latched
// row/column position.
//   i_row_idx - row index of the pressed key (0 = top row)
//   i_col_idx - column index of the pressed key (0 = leftmost column)
//   o_code    - 4-bit key code from KEY_MAP
module keypad_key_decode
  import keypad_pkg::*;
(
  input  logic [1:0] i_row_idx,
  input  logic [1:0] i_col_idx,
  output logic [3:0] o_code
);

  assign o_code = KEY_MAP[i_row_idx][i_col_idx];

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: drives the columns of a 4x4 matrix keypad one at a time,
// samples the (already synchronized) active-low rows at the end of each
// column dwell, and debounces both press and release.
//   clk       - system clock
//   reset     - synchronous, active-high reset
//   rows_n    - keypad rows, active-low
//   cols_n    - column drive, active-low one-hot (registered)
//   key_code  - code of the most recently accepted key
//   key_valid - one-cycle pulse when a press is accepted
//   key_held  - high while the accepted key stays pressed (through release debounce)
//   dbg_state - current FSM state, for observation only
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV        = 16'd4800,
  parameter logic [21:0] DEBOUNCE_CYCLES = 22'd2400000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] rows_n,
  output logic [NUM_COLS-1:0] cols_n,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_held,
  output state_t              dbg_state
);

  state_t              r_state;
  logic [1:0]          r_col_idx;
  logic [1:0]          r_row_idx;
  logic [NUM_COLS-1:0] r_cols_n;
  logic [15:0]         r_dwell;
  logic [21:0]         r_debounce;
  logic [3:0]          r_key_code;
  logic                r_key_valid;
  logic                r_key_held;

  logic       w_any_low;
  logic [1:0] w_low_row;
  logic       w_row_low;
  logic [1:0] w_next_col;
  logic [3:0] w_code;

  assign w_any_low  = ~&rows_n;
  assign w_low_row  = lowest_low_row(rows_n);
  // Once a key is latched only its own row matters; other rows are ignored.
  assign w_row_low  = ~rows_n[r_row_idx];
  assign w_next_col = r_col_idx + 2'd1;

  keypad_key_decode u_decode (
    .i_row_idx (r_row_idx),
    .i_col_idx (r_col_idx),
    .o_code    (w_code)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= SCAN;
      r_col_idx   <= 2'd0;
      r_row_idx   <= 2'd0;
      r_cols_n    <= 4'b1110;
      r_dwell     <= 16'd0;
      r_debounce  <= 22'd0;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      case (r_state)
        SCAN: begin
          if (r_dwell == SCAN_DIV - 16'd1) begin
            r_dwell <= 16'd0;
            if (w_any_low) begin
              // Column stays where it is: it is part of the latched key.
              r_row_idx  <= w_low_row;
              r_debounce <= 22'd0;
              r_state    <= DEBOUNCE_PRESS;
            end else begin
              r_col_idx <= w_next_col;
              r_cols_n  <= col_drive(w_next_col);
            end
          end else begin
            r_dwell <= r_dwell + 16'd1;
          end
        end

        DEBOUNCE_PRESS: begin
          if (!w_row_low) begin
            // Glitch: drop it and move on to the next column.
            r_debounce <= 22'd0;
            r_dwell    <= 16'd0;
            r_col_idx  <= w_next_col;
            r_cols_n   <= col_drive(w_next_col);
            r_state    <= SCAN;
          end else if (r_debounce == DEBOUNCE_CYCLES - 22'd1) begin
            r_debounce  <= 22'd0;
            r_key_code  <= w_code;
            r_key_valid <= 1'b1;
            r_key_held  <= 1'b1;
            r_state     <= HELD;
          end else begin
            r_debounce <= r_debounce + 22'd1;
          end
        end

        HELD: begin
          if (!w_row_low) begin
            r_debounce <= 22'd0;
            r_state    <= DEBOUNCE_RELEASE;
          end
        end

        DEBOUNCE_RELEASE: begin
          if (w_row_low) begin
            // Bounce back to pressed: same key, no new pulse.
            r_debounce <= 22'd0;
            r_state    <= HELD;
          end else if (r_debounce == DEBOUNCE_CYCLES - 22'd1) begin
            r_debounce <= 22'd0;
            r_dwell    <= 16'd0;
            r_key_held <= 1'b0;
            r_col_idx  <= w_next_col;
            r_cols_n   <= col_drive(w_next_col);
            r_state    <= SCAN;
          end else begin
            r_debounce <= r_debounce + 22'd1;
          end
        end

        default: r_state <= SCAN;
      endcase
    end
  end

  assign cols_n    = r_cols_n;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYCLES=8.
// A small keypad model turns the pressed-key mask plus a row override into
// rows_n, using the column the DUT is currently driving. Inputs are driven
// and outputs sampled on the falling clock edge.
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  rows_n;
  logic [3:0]  cols_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  state_t      dbg_state;

  logic [15:0] pressed;    // bit r*4+c set while key (r,c) is held down
  logic [3:0]  force_low;  // rows pulled low regardless of column
  logic [3:0]  pad_low;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  keypad_scanner #(
    .SCAN_DIV        (16'd4),
    .DEBOUNCE_CYCLES (22'd8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rows_n    (rows_n),
    .cols_n    (cols_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // keypad model
  always_comb begin
    pad_low = force_low;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols_n[c]) pad_low[r] = 1'b1;
  end
  assign rows_n = ~pad_low;

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stops on the first cycle the DUT drives the given column.
  task automatic wait_col(input logic [3:0] target);
    int n;
    n = 0;
    while (cols_n == target && n < 64) begin step(1); n++; end
    while (cols_n != target && n < 64) begin step(1); n++; end
    checks++;
    if (cols_n !== target) begin
      errors++;
      $display("FAIL wait_col timeout: cols_n=%b want %b", cols_n, target);
    end
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (key_valid !== 1'b1 && n < 80) begin step(1); n++; end
    checks++;
    if (key_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s key_valid timeout: key_valid=%b want 1", name, key_valid);
    end
  endtask

  task automatic test_reset();
    pressed = 16'h0; force_low = 4'h0;
    reset = 1'b1;
    step(3);
    checks++;
    if (cols_n !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 ||
        key_held !== 1'b0 || dbg_state !== SCAN) begin
      errors++;
      $display("FAIL reset_values: cols_n=%b code=%h valid=%b held=%b state=%0d want 1110 0 0 0 0",
               cols_n, key_code, key_valid, key_held, dbg_state);
    end
    reset = 1'b0;
    // Each column is driven for 4 cycles, then back to column 0.
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(4'b1110);
    for (int i = 0; i < 4; i++) exp_q.push_back(4'b1101);
    for (int i = 0; i < 4; i++) exp_q.push_back(4'b1011);
    for (int i = 0; i < 4; i++) exp_q.push_back(4'b0111);
    exp_q.push_back(4'b1110);
    for (int i = 0; i < 17; i++) begin
      logic [3:0] e;
      e = exp_q.pop_front();
      checks++;
      if (cols_n !== e || key_valid !== 1'b0) begin
        errors++;
        $display("FAIL scan_cols[%0d]: cols_n=%b valid=%b want %b 0", i, cols_n, key_valid, e);
      end
      step(1);
    end
  endtask

  task automatic test_press();
    pressed[1*4+1] = 1'b1;  // key "5"
    wait_col(4'b1101);
    // Sample is 3 cycles later; key_valid 9 cycles after the sample.
    for (int k = 1; k <= 13; k++) begin
      step(1);
      checks++;
      if (key_valid !== (k == 12) || cols_n !== 4'b1101 ||
          key_code !== ((k >= 12) ? 4'h5 : 4'h0) || key_held !== (k >= 12)) begin
        errors++;
        $display("FAIL press_5[%0d]: valid=%b cols_n=%b code=%h held=%b want %b 1101 %h %b",
                 k, key_valid, cols_n, key_code, key_held, (k == 12),
                 (k >= 12) ? 4'h5 : 4'h0, (k >= 12));
      end
    end
  endtask

  task automatic test_release_bounce();
    logic [3:0] e_cols;
    pressed[1*4+1] = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      step(1);
      e_cols = (k <= 13) ? 4'b1101 : (k <= 17) ? 4'b1011 : 4'b0111;
      checks++;
      if (key_held !== (k <= 13) || key_valid !== 1'b0 || cols_n !== e_cols ||
          key_code !== 4'h5) begin
        errors++;
        $display("FAIL release_bounce[%0d]: held=%b valid=%b cols_n=%b code=%h want %b 0 %b 5",
                 k, key_held, key_valid, cols_n, key_code, (k <= 13), e_cols);
      end
      if (k == 3) pressed[1*4+1] = 1'b1;
      if (k == 5) pressed[1*4+1] = 1'b0;
    end
  endtask

  task automatic test_glitch();
    logic [3:0] e_cols;
    wait_col(4'b0111);
    for (int k = 1; k <= 11; k++) begin
      step(1);
      e_cols = (k <= 6) ? 4'b0111 : (k <= 10) ? 4'b1110 : 4'b1101;
      checks++;
      if (key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'h5 || cols_n !== e_cols) begin
        errors++;
        $display("FAIL glitch[%0d]: valid=%b held=%b code=%h cols_n=%b want 0 0 5 %b",
                 k, key_valid, key_held, key_code, cols_n, e_cols);
      end
      if (k == 3) force_low = 4'b0001;
      if (k == 6) force_low = 4'b0000;
    end
  endtask

  task automatic test_two_keys();
    int n;
    pressed[3*4+0] = 1'b1;  // "E"
    pressed[0*4+0] = 1'b1;  // "1"
    wait_valid("two_keys");
    checks++;
    if (key_code !== 4'h1 || key_held !== 1'b1 || cols_n !== 4'b1110) begin
      errors++;
      $display("FAIL two_keys_code: code=%h held=%b cols_n=%b want 1 1 1110", key_code, key_held, cols_n);
    end
    pressed[2*4+2] = 1'b1;  // "9"
    pressed[2*4+0] = 1'b1;  // "7", same column, visible on the rows
    for (int k = 0; k < 30; k++) begin
      step(1);
      checks++;
      if (key_valid !== 1'b0 || key_code !== 4'h1 || key_held !== 1'b1 || cols_n !== 4'b1110) begin
        errors++;
        $display("FAIL extra_key_ignored[%0d]: valid=%b code=%h held=%b cols_n=%b want 0 1 1 1110",
                 k, key_valid, key_code, key_held, cols_n);
      end
    end
    pressed = 16'h0;
    n = 0;
    while (key_held !== 1'b0 && n < 40) begin step(1); n++; end
    checks++;
    if (key_held !== 1'b0 || n != 9) begin
      errors++;
      $display("FAIL two_keys_release: held=%b after %0d cycles want 0 after 9", key_held, n);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    // Reset while debouncing a press of "6".
    pressed[1*4+2] = 1'b1;
    wait_col(4'b1011);
    step(5);
    reset = 1'b1;
    step(1);
    checks++;
    if (cols_n !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 ||
        key_held !== 1'b0 || dbg_state !== SCAN) begin
      errors++;
      $display("FAIL reset_in_press: cols_n=%b code=%h valid=%b held=%b want 1110 0 0 0",
               cols_n, key_code, key_valid, key_held);
    end
    pressed = 16'h0;
    step(1);
    reset = 1'b0;
    // Reset while "D" is held.
    pressed[3*4+3] = 1'b1;
    wait_valid("press_d");
    checks++;
    if (key_code !== 4'hD) begin
      errors++;
      $display("FAIL press_d_code: code=%h want d", key_code);
    end
    step(2);
    reset = 1'b1;
    step(1);
    checks++;
    if (cols_n !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 ||
        key_held !== 1'b0 || dbg_state !== SCAN) begin
      errors++;
      $display("FAIL reset_in_held: cols_n=%b code=%h valid=%b held=%b want 1110 0 0 0",
               cols_n, key_code, key_valid, key_held);
    end
    pressed = 16'h0;
    step(1);
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (key_valid === 1'b1 || key_held === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL after_reset_quiet: %0d active cycles want 0", pulses);
    end
  endtask

  initial begin
    reset = 1'b1;
    pressed = 16'h0;
    force_low = 4'h0;
    test_reset();
    test_press();
    test_release_bounce();
    test_glitch();
    test_two_keys();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
